// File: rtl/lvds_iq_framer.sv
// lvds_iq_framer
//   Hunts for the I/Q sync pattern in a DDR modem stream (one bit-pair per clock),
//   assembles 32-bit frames {I_sync,I[12:0],i_ctrl,Q_sync,Q[12:0],q_ctrl} and pushes
//   them into an RX FIFO once LOCK_FRAMES consecutive good frames have been seen.
//   Optional feature macro: RX_TEST_PATTERN_EN (test-pattern words under i_test_mode).
// Ports:
//   i_sys_clk, i_reset          clock, async active-high reset
//   i_ddr_data[1:0]             captured pair, [1] first in time
//   i_enable                    allow FIFO pushes
//   i_clear_cnts                sync clear of both status counters
//   i_test_mode                 select test-pattern words (feature builds only)
//   o_fifo_push, o_fifo_data    registered write strobe / frame word
//   i_fifo_full                 RX FIFO full
//   o_locked                    framer locked
//   o_sync_err_cnt              saturating sync-mismatch count
//   o_overflow_cnt              saturating dropped-frame count
module lvds_iq_framer #(
    parameter logic [1:0]  SYNC_I      = 2'b10,
    parameter logic [1:0]  SYNC_Q      = 2'b01,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_ddr_data,
    input  logic             i_enable,
    input  logic             i_clear_cnts,
    input  logic             i_test_mode,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_data,
    input  logic             i_fifo_full,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_sync_err_cnt,
    output logic [CNT_W-1:0] o_overflow_cnt
);

    localparam int unsigned      GoodW   = $clog2(LOCK_FRAMES + 1);
    localparam logic [GoodW-1:0] LockVal = GoodW'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [2:0] {StHunt, StIData, StQSync, StQData, StISync} state_e;

    state_e             state_q, state_d;
    logic [2:0]         pair_cnt_q, pair_cnt_d;
    logic [29:0]        shift_q, shift_d;
    logic [GoodW-1:0]   good_q, good_d, good_next;
    logic               locked_q, locked_d;
    logic               push_q, push_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [31:0]        frame_word;
    logic               sync_err, frame_done, eligible, err_inc, ovf_inc;

`ifdef RX_TEST_PATTERN_EN
    logic [12:0]        tp_cnt_q, tp_cnt_d;
`else
    logic               unused_test_mode;
    assign unused_test_mode = i_test_mode;
`endif

    // The last 15 pairs plus the current one always span a whole frame when it
    // completes; the sync pairs inside it were already checked by the FSM.
    assign frame_word = {shift_q, i_ddr_data};

    always_comb begin
        state_d    = state_q;
        pair_cnt_d = pair_cnt_q;
        shift_d    = {shift_q[27:0], i_ddr_data};
        good_d     = good_q;
        locked_d   = locked_q;
        push_d     = 1'b0;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        sync_err   = 1'b0;
        frame_done = 1'b0;
        err_inc    = 1'b0;
        ovf_inc    = 1'b0;
`ifdef RX_TEST_PATTERN_EN
        tp_cnt_d   = tp_cnt_q;
`endif

        case (state_q)
            StHunt: begin
                if (i_ddr_data == SYNC_I) begin
                    state_d    = StIData;
                    pair_cnt_d = 3'd0;
                end
            end
            StIData: begin
                if (pair_cnt_q == 3'd6) begin
                    state_d    = StQSync;
                    pair_cnt_d = 3'd0;
                end else begin
                    pair_cnt_d = pair_cnt_q + 3'd1;
                end
            end
            StQSync: begin
                if (i_ddr_data == SYNC_Q) state_d = StQData;
                else                      sync_err = 1'b1;
            end
            StQData: begin
                if (pair_cnt_q == 3'd6) begin
                    frame_done = 1'b1;
                    state_d    = StISync;
                    pair_cnt_d = 3'd0;
                end else begin
                    pair_cnt_d = pair_cnt_q + 3'd1;
                end
            end
            StISync: begin
                if (i_ddr_data == SYNC_I) begin
                    state_d    = StIData;
                    pair_cnt_d = 3'd0;
                end else begin
                    sync_err = 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase

        if (sync_err) begin
            state_d  = StHunt;
            good_d   = '0;
            locked_d = 1'b0;
            // Misses before any good frame are just hunting, not errors.
            err_inc  = (good_q != '0) || locked_q;
        end

        good_next = (good_q == LockVal) ? good_q : good_q + 1'b1;
        eligible  = frame_done && (good_next == LockVal);

        if (frame_done) begin
            good_d = good_next;
            if (eligible) locked_d = 1'b1;
        end

        if (eligible && i_enable) begin
            if (!i_fifo_full) begin
                push_d = 1'b1;
                data_d = frame_word;
`ifdef RX_TEST_PATTERN_EN
                if (i_test_mode) begin
                    data_d   = {SYNC_I, tp_cnt_q, 1'b0, SYNC_Q, ~tp_cnt_q, 1'b0};
                    tp_cnt_d = tp_cnt_q + 13'd1;
                end
`endif
            end else begin
                ovf_inc = 1'b1;
            end
        end

        // Clear wins over a same-cycle increment.
        if (i_clear_cnts)                        err_cnt_d = '0;
        else if (err_inc && err_cnt_q != CntMax) err_cnt_d = err_cnt_q + 1'b1;

        if (i_clear_cnts)                        ovf_cnt_d = '0;
        else if (ovf_inc && ovf_cnt_q != CntMax) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StHunt;
            pair_cnt_q <= '0;
            shift_q    <= '0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            push_q     <= 1'b0;
            data_q     <= '0;
            err_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pair_cnt_q <= pair_cnt_d;
            shift_q    <= shift_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            push_q     <= push_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

`ifdef RX_TEST_PATTERN_EN
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) tp_cnt_q <= '0;
        else         tp_cnt_q <= tp_cnt_d;
    end
`endif

    assign o_fifo_push    = push_q;
    assign o_fifo_data    = data_q;
    assign o_locked       = locked_q;
    assign o_sync_err_cnt = err_cnt_q;
    assign o_overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_lvds_iq_framer.sv
// Directed bench for lvds_iq_framer: reset, lock/push, bad Q sync, FIFO full with
// counter saturation and clear, enable gating, mid-frame reset and (feature builds)
// test-pattern words.
module tb_lvds_iq_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ddr = 2'b00;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic        test_mode = 1'b0;
    logic        full = 1'b0;
    logic        push;
    logic [31:0] data;
    logic        locked;
    logic [7:0]  err_cnt;
    logic [7:0]  ovf_cnt;

    int compared = 0;
    int mismatched = 0;
    int push_cnt = 0;
    time t_ref;

    lvds_iq_framer dut (
        .i_sys_clk      (clk),
        .i_reset        (rst),
        .i_ddr_data     (ddr),
        .i_enable       (enable),
        .i_clear_cnts   (clear),
        .i_test_mode    (test_mode),
        .o_fifo_push    (push),
        .o_fifo_data    (data),
        .i_fifo_full    (full),
        .o_locked       (locked),
        .o_sync_err_cnt (err_cnt),
        .o_overflow_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (push === 1'b1) push_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic [1:0] p);
        @(negedge clk);
        ddr = p;
    endtask

    // Sends the first n pairs of a frame MSB-first, pulsing clear with pair clear_at,
    // then returns #1 after the edge that samples the last pair.
    task automatic send_frame(input logic [12:0] i_d, input logic ic, input logic [1:0] qs,
                              input logic [12:0] q_d, input logic qc, input int n,
                              input int clear_at);
        logic [31:0] w;
        w = {2'b10, i_d, ic, qs, q_d, qc};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ddr   = w[31-2*k -: 2];
            clear = (k == clear_at);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic good_frame();
        send_frame(13'h0ABC, 1'b1, 2'b01, 13'h1234, 1'b0, 16, -1);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        check("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) send_pair(2'b00);
        @(posedge clk);
        #1;
        check("idle_pushes", push_cnt, 0);
        check("idle_err", {24'd0, err_cnt}, 32'd0);

        // Lock and push
        good_frame();
        check("f1_push", {31'd0, push}, 32'd0);
        check("f1_locked", {31'd0, locked}, 32'd0);
        good_frame();
        t_ref = $time;
        check("f2_push", {31'd0, push}, 32'd1);
        check("f2_data", data, 32'h95796468);
        check("f2_locked", {31'd0, locked}, 32'd1);
        good_frame();
        check("f3_push", {31'd0, push}, 32'd1);
        check("f3_spacing", 32'($time - t_ref), 32'd160);
        check("f3_err", {24'd0, err_cnt}, 32'd0);

        // Bad Q sync while locked; stream resumes right after the bad pair
        send_frame(13'h0ABC, 1'b1, 2'b11, 13'h1234, 1'b0, 9, -1);
        check("bad_err", {24'd0, err_cnt}, 32'd1);
        check("bad_locked", {31'd0, locked}, 32'd0);
        check("bad_push", {31'd0, push}, 32'd0);
        good_frame();
        check("relock1_push", {31'd0, push}, 32'd0);
        check("relock1_locked", {31'd0, locked}, 32'd0);
        good_frame();
        check("relock2_push", {31'd0, push}, 32'd1);
        check("relock2_locked", {31'd0, locked}, 32'd1);

        // FIFO full: drops saturate the overflow counter
        full = 1'b1;
        for (int f = 0; f < 300; f++) good_frame();
        check("full_pushes", push_cnt, 3);
        check("full_ovf", {24'd0, ovf_cnt}, 32'd255);
        check("full_locked", {31'd0, locked}, 32'd1);
        check("full_err", {24'd0, err_cnt}, 32'd1);
        send_frame(13'h0ABC, 1'b1, 2'b01, 13'h1234, 1'b0, 16, 5);
        check("clr_ovf", {24'd0, ovf_cnt}, 32'd1);
        check("clr_err", {24'd0, err_cnt}, 32'd0);
        send_frame(13'h0ABC, 1'b1, 2'b01, 13'h1234, 1'b0, 16, 15);
        check("clr_drop_ovf", {24'd0, ovf_cnt}, 32'd0);

        // Enable low: no drops counted, lock kept
        enable = 1'b0;
        good_frame();
        check("dis_ovf", {24'd0, ovf_cnt}, 32'd0);
        check("dis_locked", {31'd0, locked}, 32'd1);
        enable = 1'b1;
        full = 1'b0;
        good_frame();
        check("en_push", {31'd0, push}, 32'd1);

        // Reset at I data pair 4
        send_frame(13'h0ABC, 1'b1, 2'b01, 13'h1234, 1'b0, 5, -1);
        rst = 1'b1;
        #1;
        check("mrst_locked", {31'd0, locked}, 32'd0);
        check("mrst_push", {31'd0, push}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        good_frame();
        check("mrst_f1_push", {31'd0, push}, 32'd0);
        check("mrst_f1_locked", {31'd0, locked}, 32'd0);
        good_frame();
        check("mrst_f2_push", {31'd0, push}, 32'd1);
        check("mrst_f2_data", data, 32'h95796468);

`ifdef RX_TEST_PATTERN_EN
        test_mode = 1'b1;
        send_frame(13'h1555, 1'b0, 2'b01, 13'h0AAA, 1'b1, 16, -1);
        check("tp0_data", data, 32'h80007FFE);
        send_frame(13'h1555, 1'b0, 2'b01, 13'h0AAA, 1'b1, 16, -1);
        check("tp1_data", data, 32'h80027FFC);
        test_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
